// File: rtl/fp_align_stage.sv
// Exponent compare and mantissa alignment for the single-precision FP adder.
// The smaller mantissa is shifted right one bit per cycle, and shifted-out bits collapse into a sticky bit.

module fp_align_cpl #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = ~x;
endmodule

module fp_align_stage #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int MAX_SHIFT = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          a,
    input  logic [31:0]          b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W-1:0]     exp_out,
    output logic [MAN_W+3:0]     man_big,
    output logic [MAN_W+3:0]     man_small,
    output logic                 sign_big,
    output logic                 sign_small,
    output logic                 swapped,
    output logic                 special
);
    localparam int AW = MAN_W + 4;
    localparam int CW = $clog2(MAX_SHIFT + 1);

    // state | meaning
    // IDLE  | waiting for an operand pair
    // SHIFT | shifting the smaller mantissa, one bit per cycle
    // DONE  | result presented, waiting for out_ready
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] MAX_D   = EXP_W'(MAX_SHIFT);
    localparam logic [CW-1:0]    MAX_K   = CW'(MAX_SHIFT);
    localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CW-1:0]    count;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff, eb_cpl, d;
    logic [MAN_W-1:0] fa, fb;
    logic [AW-1:0]    man_a, man_b;
    logic [EXP_W:0]   diff9;
    logic             a_big, special_in;
    logic [CW-1:0]    k_in;

    assign sa = a[EXP_W+MAN_W];
    assign sb = b[EXP_W+MAN_W];
    assign ea = a[EXP_W+MAN_W-1 -: EXP_W];
    assign eb = b[EXP_W+MAN_W-1 -: EXP_W];
    assign fa = a[MAN_W-1:0];
    assign fb = b[MAN_W-1:0];

    // Denormals carry the same effective exponent as the smallest normal.
    assign ea_eff = (ea == '0) ? EXP_ONE : ea;
    assign eb_eff = (eb == '0) ? EXP_ONE : eb;
    assign man_a  = {|ea, fa, 3'b000};
    assign man_b  = {|eb, fb, 3'b000};

    fp_align_cpl #(.W(EXP_W)) u_cpl (
        .x(eb_eff),
        .y(eb_cpl)
    );

    assign diff9      = {1'b0, ea_eff} + {1'b0, eb_cpl} + {{EXP_W{1'b0}}, 1'b1};
    assign a_big      = diff9[EXP_W];
    assign d          = a_big ? diff9[EXP_W-1:0] : (~diff9[EXP_W-1:0] + EXP_ONE);
    assign special_in = (&ea) | (&eb);

    always_comb begin
        k_in = '0;
        if (!special_in) begin
            if (d > MAX_D) k_in = MAX_K;
            else           k_in = d[CW-1:0];
        end
    end

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            exp_out    <= '0;
            man_big    <= '0;
            man_small  <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            swapped    <= 1'b0;
            special    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        exp_out    <= a_big ? ea_eff : eb_eff;
                        man_big    <= a_big ? man_a : man_b;
                        man_small  <= a_big ? man_b : man_a;
                        sign_big   <= a_big ? sa : sb;
                        sign_small <= a_big ? sb : sa;
                        swapped    <= ~a_big;
                        special    <= special_in;
                        count      <= k_in;
                        state      <= (k_in == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    // Bit 0 accumulates everything shifted past it.
                    man_small <= {1'b0, man_small[AW-1:2], man_small[1] | man_small[0]};
                    count     <= count - CNT_ONE;
                    if (count == CNT_ONE) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_stage.sv
// Randomized and directed bench for fp_align_stage, checked against an arithmetic reference model.

module tb_fp_align_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [26:0] man_big, man_small;
    logic        sign_big, sign_small, swapped, special;

    int n_checks = 0;
    int n_fails  = 0;

    fp_align_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .man_big(man_big), .man_small(man_small),
        .sign_big(sign_big), .sign_small(sign_small), .swapped(swapped),
        .special(special)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: order by effective exponent, then a sticky right shift by min(|diff|, 27).
    task automatic model(input logic [31:0] av, input logic [31:0] bv,
                         output int e_exp, output longint e_big, output longint e_small,
                         output int e_sb, output int e_ss, output int e_sw, output int e_sp,
                         output int e_k);
        int ea, eb, eae, ebe, d;
        longint ma, mb, ms;
        ea  = int'(av[30:23]);
        eb  = int'(bv[30:23]);
        eae = (ea == 0) ? 1 : ea;
        ebe = (eb == 0) ? 1 : eb;
        ma  = ((ea != 0 ? 64'd1 << 23 : 64'd0) + longint'(av[22:0])) * 8;
        mb  = ((eb != 0 ? 64'd1 << 23 : 64'd0) + longint'(bv[22:0])) * 8;
        e_sp = (ea == 255 || eb == 255) ? 1 : 0;
        if (eae >= ebe) begin
            e_exp = eae; e_big = ma; ms = mb; e_sb = int'(av[31]); e_ss = int'(bv[31]); e_sw = 0;
            d = eae - ebe;
        end else begin
            e_exp = ebe; e_big = mb; ms = ma; e_sb = int'(bv[31]); e_ss = int'(av[31]); e_sw = 1;
            d = ebe - eae;
        end
        e_k = (e_sp != 0) ? 0 : ((d > 27) ? 27 : d);
        e_small = (ms >> e_k) | (((ms & ((64'd1 << e_k) - 1)) != 0) ? 64'd1 : 64'd0);
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int stall,
                          output logic [26:0] small_got);
        int e_exp, e_sb, e_ss, e_sw, e_sp, e_k, lat;
        longint e_big, e_small;
        model(av, bv, e_exp, e_big, e_small, e_sb, e_ss, e_sw, e_sp, e_k);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("latency", lat, e_k + 1);
        check("exp_out", exp_out, e_exp);
        check("man_big", man_big, e_big);
        check("man_small", man_small, e_small);
        check("sign_big", sign_big, e_sb);
        check("sign_small", sign_small, e_ss);
        check("swapped", swapped, e_sw);
        check("special", special, e_sp);
        small_got = man_small;
        repeat (stall) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_small", man_small, e_small);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [26:0] got_small;
    logic [26:0] ref_big, ref_small;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_man_big", man_big, 0);
        check("rst_exp_out", exp_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        run_op(32'h3F800000, 32'h3F800000, 0, got_small);
        check("t1_small", got_small, 27'h4000000);
        run_op(32'h3F800000, 32'h3F000000, 1, got_small);
        check("t2_small", got_small, 27'h2000000);
        run_op(32'h3F000000, 32'h3F800000, 0, got_small);
        check("t3_small", got_small, 27'h2000000);
        run_op(32'h4B800000, 32'h3F800001, 0, got_small);
        check("t4_small", got_small, 27'h0000005);
        run_op(32'h71800000, 32'h3F800000, 2, got_small);
        check("t5_small", got_small, 27'h0000001);
        run_op(32'h7F800000, 32'h3F800001, 0, got_small);
        run_op(32'h00000003, 32'h00800001, 0, got_small);

        for (int i = 0; i < 40; i++) begin
            int ea, eb, r;
            logic [31:0] av, bv;
            ea = $urandom_range(0, 254);
            r  = $urandom_range(0, 9);
            if (r == 0)      begin eb = 0; ea = $urandom_range(0, 3); end
            else if (r == 1) eb = 255;
            else begin
                eb = ea + $urandom_range(0, 60) - 30;
                if (eb < 0)   eb = 0;
                if (eb > 254) eb = 254;
            end
            av = {1'($urandom), 8'(ea), 23'($urandom)};
            bv = {1'($urandom), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 1) == 1) run_op(av, bv, $urandom_range(0, 2), got_small);
            else                           run_op(bv, av, $urandom_range(0, 2), got_small);
        end

        // Backpressure: held DONE ignores new operands and keeps outputs stable.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F000000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        a = 32'h4B800000; b = 32'hBF800001;
        repeat (2) @(negedge clk);
        check("bp_valid", out_valid, 1);
        ref_big = man_big; ref_small = man_small;
        check("bp_small_value", ref_small, 27'h2000000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_big", man_big, ref_big);
            check("bp_hold_small", man_small, ref_small);
            check("bp_hold_exp", exp_out, 8'h7F);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", in_ready, 1);

        // Reset in the middle of a long shift drops the operation.
        a = 32'h71800000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_shift_valid", out_valid, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_shift_valid", out_valid, 0);
        check("rst_shift_in_ready", in_ready, 0);
        check("rst_shift_small", man_small, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", in_ready, 1);
        check("rst_release_valid", out_valid, 0);

        run_op(32'hC0400000, 32'h3F800000, 0, got_small);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
